sdu_uart_rx_fifo: RTL and testbench
===================================

// Module: sdu_uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver for the serial debug unit: deserialises rxd, checks
//  optional parity and stop bit, and buffers frames in a FIFO whose head is offered
//  to the DCP on a valid/ready interface.
//  Replaces the unbuffered uart_rx so bytes are not lost while the DCP is busy.
//  Adds configurable data width and parity, sticky error flags and a fill level.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); must be >= 4
//  DATA_W        8    data bits per frame, 5..9, sent LSB first
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  FIFO_DEPTH    16   entries; power of two, >= 2
// PORTS
//  clk         in   1                      system clock (dclk domain)
//  rst         in   1                      synchronous, active-high reset
//  rxd         in   1                      asynchronous serial line, idle high
//  d_rx        out  DATA_W                 FIFO head data
//  vld_rx      out  1                      FIFO not empty
//  rdy_rx      in   1                      consumer accepts d_rx this cycle
//  level       out  $clog2(FIFO_DEPTH)+1   current entry count
//  frame_err   out  1                      sticky: stop bit sampled low
//  parity_err  out  1                      sticky: parity mismatch
//  overrun     out  1                      sticky: good frame dropped, FIFO full
//  clr_err     in   1                      clears all three sticky flags
// BEHAVIOUR
//  Reset: FSM IDLE; counters, pointers and level 0; vld_rx=0; d_rx=0; error flags 0;
//   both synchroniser flops =1.
//  rxd passes through 2 FFs (rxd_s); all FSM decisions use rxd_s only.
//  FSM (cnt = bit timer, bitn = data bit index):
//   IDLE: rxd_s==0 -> START, cnt=0.
//   START: at cnt==CLKS_PER_BIT/2-1 resample; 0 -> DATA, cnt=0; 1 (glitch) -> IDLE.
//   DATA: at cnt==CLKS_PER_BIT-1 shift in rxd_s, cnt=0; after bit DATA_W-1 ->
//    PARITY if PARITY!=0, else STOP.
//   PARITY: at cnt==CLKS_PER_BIT-1 compare rxd_s with the expected bit (odd: XOR of
//    data bits inverted; even: XOR of data bits); go STOP, holding the mismatch.
//   STOP: at cnt==CLKS_PER_BIT-1 sample; 1 -> frame complete, IDLE;
//    0 -> set frame_err, discard frame, -> BREAK.
//   BREAK: wait for rxd_s==1, then IDLE (a held-low line yields exactly one frame_err).
//  Frame complete with parity mismatch: set parity_err, discard (no push).
//  Good frame: push pulses 1 cycle in the cycle after the stop sample.
//   d_rx/vld_rx update the following cycle.
//  FIFO is first-word-fall-through: d_rx = mem[rd_ptr] whenever vld_rx=1.
//   pop = vld_rx & rdy_rx; d_rx is don't-care while vld_rx=0.
//  push & pop in the same cycle: both take effect, level unchanged; allowed when full.
//  push while full and no pop: data dropped, overrun=1, pointers unchanged.
//  Pointers wrap modulo FIFO_DEPTH; level = 0..FIFO_DEPTH, never overflows.
//  Sticky flags: set has priority over clr_err in the same cycle.
//  rst mid-frame: partial frame discarded; FIFO emptied; the receiver resyncs on the
//   next falling edge seen in IDLE; a frame already in progress at rst release may
//   give one frame_err.
//  Total latency: rxd stop-bit midpoint to vld_rx high = 2 (sync) + 2 cycles.
// TESTING (CLKS_PER_BIT=16, DATA_W=8, FIFO_DEPTH=4 unless stated)
//  Send 0xA5, 8N1, rdy_rx=1 -> vld_rx for 1 cycle with d_rx=0xA5; level returns to 0.
//  Send 0x00,0x11,0x22,0x33,0x44 with rdy_rx=0 -> level=4, overrun=1;
//   pops yield 0x00..0x33 in order.
//  PARITY=2: send 0x07 with parity bit 0 -> parity_err=1, level 0;
//   send 0x07 with parity 1 -> accepted.
//  Stop bit driven 0, then line held low 100 bit times -> frame_err=1 once, no push;
//   next valid frame 0x3C accepted.
//  Low pulse of 4 cycles on idle line -> no frame, no errors.
//   Assert clr_err -> all sticky flags clear.
//  FIFO full, pop on the same cycle as a push -> level stays 4, no overrun, order kept.
//   Assert rst mid-byte -> level 0, vld_rx 0.

Source files
------------

// File: rtl/sdu_uart_rx_fifo.sv
// sdu_uart_rx_fifo: UART receiver with parity/stop checking, sticky errors and a FWFT FIFO
module sdu_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_W-1:0]             d_rx,
  output logic                          vld_rx,
  input  logic                          rdy_rx,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clr_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} st_t;
  st_t st, st_nx;
  logic rxd_m, rxd_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitn;
  logic [DATA_W-1:0] sh;
  logic par_bad, push_q, tick, last_bit, stop_smp, exp_par, full, pop, push_ok;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // two-flop synchroniser, idle-high so reset does not look like a start bit
  always_ff @(posedge clk)
    if (rst) {rxd_m, rxd_s} <= 2'b11;
    else {rxd_m, rxd_s} <= {rxd, rxd_m};
  // state register
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= st_nx;
  // next-state logic
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:  st_nx = rxd_s ? IDLE : START;
      START: st_nx = tick ? (rxd_s ? IDLE : DATA) : START;
      DATA:  st_nx = (tick && last_bit) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:   st_nx = tick ? STOP : PAR;
      STOP:  st_nx = tick ? (rxd_s ? IDLE : BRK) : STOP;
      BRK:   st_nx = rxd_s ? IDLE : BRK;
      default: st_nx = IDLE;
    endcase
  end
  // FSM-derived strobes: start bit sampled at half period, the rest at full period
  always_comb begin
    tick = (st == START) ? (cnt == CW'(CLKS_PER_BIT/2 - 1)) : (cnt == CW'(CLKS_PER_BIT - 1));
    last_bit = bitn == BW'(DATA_W - 1);
    stop_smp = (st == STOP) && tick;
    exp_par = (PARITY == 1) ? ~^sh : ^sh;
  end
  // bit timer, data shifter and parity mismatch tracking
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      par_bad <= 1'b0;
      push_q <= 1'b0;
    end else begin
      cnt <= (st == IDLE || st == BRK || tick) ? '0 : cnt + 1'b1;
      bitn <= (st == IDLE) ? '0 : (st == DATA && tick) ? bitn + 1'b1 : bitn;
      sh <= (st == DATA && tick) ? {rxd_s, sh[DATA_W-1:1]} : sh;
      par_bad <= (st == IDLE) ? 1'b0 : (st == PAR && tick) ? (rxd_s != exp_par) : par_bad;
      push_q <= stop_smp && rxd_s && !par_bad;
    end
  // sticky error flags, set wins over clear
  always_ff @(posedge clk)
    if (rst) {frame_err, parity_err, overrun} <= 3'b000;
    else begin
      frame_err <= (stop_smp && !rxd_s) || (frame_err && !clr_err);
      parity_err <= (stop_smp && rxd_s && par_bad) || (parity_err && !clr_err);
      overrun <= (push_q && full && !pop) || (overrun && !clr_err);
    end
  // FIFO status and head; a push into a full FIFO is fine when the head leaves the same cycle
  always_comb begin
    full = level == LW'(FIFO_DEPTH);
    vld_rx = level != '0;
    pop = vld_rx && rdy_rx;
    push_ok = push_q && (!full || pop);
    d_rx = vld_rx ? mem[rd_ptr] : '0;
  end
  // FIFO storage
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= sh;
  // FIFO pointers and fill level
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + LW'(push_ok) - LW'(pop);
    end
endmodule

// File: tb/tb_sdu_uart_rx_fifo.sv
// tb_sdu_uart_rx_fifo: directed self-checking bench for sdu_uart_rx_fifo
module tb_sdu_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1, rxd2 = 1'b1;
  logic rdy_rx = 1'b0, rdy_rx2 = 1'b0;
  logic clr_err = 1'b0;
  logic [7:0] d_rx, d_rx2;
  logic vld_rx, vld_rx2;
  logic [2:0] level, level2;
  logic frame_err, parity_err, overrun;
  logic frame_err2, parity_err2, overrun2;
  logic [7:0] pops [$];
  int total = 0;
  int passed = 0;
  int vld_n = 0;
  sdu_uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy_rx),
    .level(level), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .clr_err(clr_err));
  sdu_uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .rxd(rxd2), .d_rx(d_rx2), .vld_rx(vld_rx2), .rdy_rx(rdy_rx2),
    .level(level2), .frame_err(frame_err2), .parity_err(parity_err2), .overrun(overrun2),
    .clr_err(clr_err));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (vld_rx && rdy_rx) pops.push_back(d_rx);
    if (vld_rx) vld_n++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic drv(input bit sel2, input logic v);
    if (sel2) rxd2 = v;
    else rxd = v;
  endtask
  // mode 0: plain frame; 1: single-cycle pop aligned with the push; 2: check vld latency
  task automatic send(input logic [7:0] b, input bit sel2, input int pbit, input int mode);
    drv(sel2, 1'b0);
    tick(16);
    for (int i = 0; i < 8; i++) begin
      drv(sel2, b[i]);
      tick(16);
    end
    if (pbit >= 0) begin
      drv(sel2, pbit[0]);
      tick(16);
    end
    drv(sel2, 1'b1);
    if (mode == 1) begin
      tick(11);
      rdy_rx = 1'b1;
      tick(1);
      rdy_rx = 1'b0;
      tick(4);
    end else if (mode == 2) begin
      tick(11);
      chk("lat_pre_vld", {31'd0, vld_rx}, 32'd0);
      tick(1);
      chk("lat_vld", {31'd0, vld_rx}, 32'd1);
      chk("lat_data", {24'd0, d_rx}, 32'hA5);
      tick(4);
    end else tick(16);
  endtask
  initial begin
    logic [7:0] exp_q [$];
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_vld", {31'd0, vld_rx}, 32'd0);
    chk("rst_d", {24'd0, d_rx}, 32'd0);
    chk("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    // single byte, consumer always ready
    rdy_rx = 1'b1;
    send(8'hA5, 1'b0, -1, 2);
    tick(4);
    chk("a5_pops", pops.size(), 32'd1);
    chk("a5_vld_cycles", vld_n, 32'd1);
    chk("a5_level", {29'd0, level}, 32'd0);
    // overflow with stalled consumer
    rdy_rx = 1'b0;
    pops.delete();
    for (int i = 0; i < 5; i++) send(8'(i * 8'h11), 1'b0, -1, 0);
    tick(2);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_flag", {31'd0, overrun}, 32'd1);
    chk("ovf_head", {24'd0, d_rx}, 32'h00);
    rdy_rx = 1'b1;
    tick(4);
    rdy_rx = 1'b0;
    tick(2);
    chk("ovf_pops", pops.size(), 32'd4);
    exp_q = '{8'h00, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4 && i < pops.size(); i++) chk("ovf_order", {24'd0, pops[i]}, {24'd0, exp_q[i]});
    chk("ovf_drained", {29'd0, level}, 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    chk("clr_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    // short glitch on idle line
    pops.delete();
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(48);
    chk("glitch_level", {29'd0, level}, 32'd0);
    chk("glitch_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    // stop bit low followed by a long break
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = i[0] ? 1'b0 : 1'b1;
      tick(16);
    end
    rxd = 1'b0;
    tick(16);
    chk("brk_frame_err", {31'd0, frame_err}, 32'd1);
    chk("brk_level", {29'd0, level}, 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1600);
    chk("brk_single_err", {31'd0, frame_err}, 32'd0);
    rxd = 1'b1;
    tick(32);
    rdy_rx = 1'b1;
    send(8'h3C, 1'b0, -1, 0);
    tick(4);
    rdy_rx = 1'b0;
    chk("brk_recover_n", pops.size(), 32'd1);
    if (pops.size() > 0) chk("brk_recover_d", {24'd0, pops[0]}, 32'h3C);
    chk("brk_no_err", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    // full FIFO with pop coinciding with push
    pops.delete();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, -1, 0);
    tick(2);
    chk("full_level", {29'd0, level}, 32'd4);
    send(8'h05, 1'b0, -1, 1);
    tick(2);
    chk("pp_level", {29'd0, level}, 32'd4);
    chk("pp_overrun", {31'd0, overrun}, 32'd0);
    rdy_rx = 1'b1;
    tick(6);
    rdy_rx = 1'b0;
    tick(2);
    chk("pp_pops", pops.size(), 32'd5);
    for (int i = 0; i < 5 && i < pops.size(); i++) chk("pp_order", {24'd0, pops[i]}, 32'(i + 1));
    // even parity on the second instance
    send(8'h07, 1'b1, 0, 0);
    tick(2);
    chk("par_err", {31'd0, parity_err2}, 32'd1);
    chk("par_level0", {29'd0, level2}, 32'd0);
    send(8'h07, 1'b1, 1, 0);
    tick(2);
    chk("par_ok_level", {29'd0, level2}, 32'd1);
    chk("par_ok_data", {24'd0, d_rx2}, 32'h07);
    chk("par_no_frame_err", {31'd0, frame_err2}, 32'd0);
    // reset in the middle of a byte
    pops.delete();
    send(8'h99, 1'b0, -1, 0);
    tick(2);
    chk("pre_rst_level", {29'd0, level}, 32'd1);
    rxd = 1'b0;
    tick(16);
    rxd = 1'b1;
    tick(16);
    rxd = 1'b0;
    tick(16);
    rst = 1'b1;
    tick(2);
    rxd = 1'b1;
    rst = 1'b0;
    tick(1);
    chk("midrst_level", {29'd0, level}, 32'd0);
    chk("midrst_vld", {31'd0, vld_rx}, 32'd0);
    chk("midrst_d", {24'd0, d_rx}, 32'd0);
    tick(40);
    rdy_rx = 1'b1;
    send(8'h5A, 1'b0, -1, 0);
    tick(4);
    chk("post_rst_n", pops.size(), 32'd1);
    if (pops.size() > 0) chk("post_rst_d", {24'd0, pops[0]}, 32'h5A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
